regfile: RTL and testbench

General-purpose register file for the 5-stage CPU: 32 × 32-bit registers answering the two read requests issued by the decode stage (`reg1_read`/`reg1_addr`, `reg2_read`/`reg2_addr`) and accepting one write per cycle from write-back. Reads are combinational, so decode samples `rdataN_o` on the same edge its request is registered into the next stage. Same-cycle write-to-read bypass is provided. After reset, an internal sequencer clears every register; the result is that no X values reach the datapath.

---
 rtl/regfile.sv | 117 +++++++++++
 tb/tb_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 32 x 32-bit register file with combinational dual read, same-cycle write bypass,
// and a post-reset clear sequencer that zeroes r1..r31 before accepting traffic.
module regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re1_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic          re2_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o,
    output logic          init_busy_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX  = {AW{1'b1}};
    localparam logic [AW-1:0] FIRST_IDX = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    state_t          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic [AW-1:0]   clr_idx_d;
    logic            init_busy_q;
    logic            wr_en_s;
    logic [DW-1:0]   mem_q [2**AW];

    // r0 reads as zero by construction; blocked reads also return zero
    function automatic logic [DW-1:0] read_port(
        input logic          blocked,
        input logic          en,
        input logic [AW-1:0] addr,
        input logic          we,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdata,
        input logic [DW-1:0] stored
    );
        logic [DW-1:0] val;
        if (blocked) begin
            val = {DW{1'b0}};
        end else if (!en) begin
            val = {DW{1'b0}};
        end else if (addr == ZERO_ADDR) begin
            val = {DW{1'b0}};
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Next clear index and write qualification
    always_comb begin
        clr_idx_d = clr_idx_q + FIRST_IDX;
        wr_en_s   = we_i && (waddr_i != ZERO_ADDR) && (state_q == READY) && !reset_n;
    end

    // Clear sequencer: restarts on every reset edge, walks r1..r31 once
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= CLEAR;
            clr_idx_q   <= FIRST_IDX;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q     <= READY;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_idx_q   <= clr_idx_d;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q     <= CLEAR;
                    clr_idx_q   <= FIRST_IDX;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage: clearing has priority, writes only land once READY
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if (state_q == CLEAR) begin
                mem_q[clr_idx_q] <= {DW{1'b0}};
            end else if (wr_en_s) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end
    end

    // Combinational read ports with write bypass
    always_comb begin
        rdata1_o = read_port(reset_n || init_busy_q, re1_i, raddr1_i,
                             we_i, waddr_i, wdata_i, mem_q[raddr1_i]);
        rdata2_o = read_port(reset_n || init_busy_q, re2_i, raddr2_i,
                             we_i, waddr_i, wdata_i, mem_q[raddr2_i]);
    end

    assign init_busy_o = init_busy_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        re1_i = 1'b0;
    logic [4:0]  raddr1_i = 5'd0;
    logic        re2_i = 1'b0;
    logic [4:0]  raddr2_i = 5'd0;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic        init_busy_o;

    int errors = 0;
    int checks = 0;

    regfile #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata1_o   (rdata1_o),
        .rdata2_o   (rdata2_o),
        .init_busy_o(init_busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: a plain array plus a count of clearing edges
    logic [31:0] mem_m [32];
    logic        busy_m  = 1'b1;
    logic        valid_m = 1'b0;
    int          cnt_m   = 0;

    always @(posedge clk) begin
        if (reset_n) begin
            valid_m <= 1'b1;
            busy_m  <= 1'b1;
            cnt_m   <= 0;
            for (int i = 0; i < 32; i++) mem_m[i] <= 32'd0;
        end else if (valid_m) begin
            if (busy_m) begin
                cnt_m <= cnt_m + 1;
                if (cnt_m == 30) busy_m <= 1'b0;
            end else if (we_i && waddr_i != 5'd0) begin
                mem_m[waddr_i] <= wdata_i;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (reset_n || busy_m) return 32'd0;
        if (!re || a == 5'd0) return 32'd0;
        if (we_i && waddr_i == a) return wdata_i;
        return mem_m[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (valid_m) begin
            check("busy",   {31'd0, init_busy_o}, {31'd0, busy_m});
            check("rdata1", rdata1_o, exp_rd(re1_i, raddr1_i));
            check("rdata2", rdata2_o, exp_rd(re2_i, raddr2_i));
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        @(posedge clk);
        #1;
        we_i = we; waddr_i = wa; wdata_i = wd;
        re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
    endtask

    // Counts edges from release until init_busy_o drops; optionally injects a write to r3
    task automatic count_clear(output int n, input int inject_at);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == inject_at) begin
                we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h0000_0033;
            end else begin
                we_i = 1'b0;
            end
            if (!init_busy_o) break;
        end
    endtask

    int n;

    initial begin
        // Reset for 3 cycles, checking reset-time outputs
        re1_i = 1'b1; raddr1_i = 5'd4; re2_i = 1'b1; raddr2_i = 5'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  {31'd0, init_busy_o}, 32'd1);
        check("reset_rdata1", rdata1_o, 32'd0);
        #1 reset_n = 1'b0;
        count_clear(n, 0);
        check("clear_len", n, 32'd31);

        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i + 1));
            @(negedge clk);
            check("cleared_p1", rdata1_o, 32'd0);
            check("cleared_p2", rdata2_o, 32'd0);
        end

        drive(1'b1, 5'd5, 32'h1234_ABCD, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
        @(negedge clk);
        check("r5_p1", rdata1_o, 32'h1234_ABCD);
        check("r5_p2", rdata2_o, 32'h1234_ABCD);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 1'b1, 5'd5);
        @(negedge clk);
        check("r5_re1_off", rdata1_o, 32'd0);
        check("r5_p2_again", rdata2_o, 32'h1234_ABCD);

        drive(1'b1, 5'd9, 32'h0000_0011, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1, 5'd9, 1'b1, 5'd9);
        @(negedge clk);
        check("bypass_p1", rdata1_o, 32'hDEAD_BEEF);
        check("bypass_p2", rdata2_o, 32'hDEAD_BEEF);
        drive(1'b0, 5'd9, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0);
        @(negedge clk);
        check("after_bypass", rdata1_o, 32'hDEAD_BEEF);

        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        @(negedge clk);
        check("r0_same_p1", rdata1_o, 32'd0);
        check("r0_same_p2", rdata2_o, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        @(negedge clk);
        check("r0_next_p1", rdata1_o, 32'd0);
        check("r0_next_p2", rdata2_o, 32'd0);

        // Reset mid-clear at index 10, then a dropped write during the re-clear
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd3);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1 reset_n = 1'b0;
        count_clear(n, 5);
        check("reclear_len", n, 32'd31);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd3);
        @(negedge clk);
        check("r7_cleared", rdata1_o, 32'd0);
        check("r3_dropped", rdata2_o, 32'd0);

        drive(1'b1, 5'd31, 32'h8000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 5'd1,  32'h7FFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b1, 5'd1);
        @(negedge clk);
        check("r31_p1", rdata1_o, 32'h8000_0001);
        check("r1_p2",  rdata2_o, 32'h7FFF_FFFF);

        // Randomized traffic with occasional resets; the model checks every cycle
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            reset_n  = ($urandom_range(0, 299) == 0);
            we_i     = 1'($urandom_range(0, 1));
            waddr_i  = 5'($urandom_range(0, 31));
            wdata_i  = $urandom;
            re1_i    = ($urandom_range(0, 3) != 0);
            re2_i    = ($urandom_range(0, 3) != 0);
            raddr1_i = ($urandom_range(0, 3) == 0) ? waddr_i : 5'($urandom_range(0, 31));
            raddr2_i = ($urandom_range(0, 3) == 0) ? waddr_i : 5'($urandom_range(0, 31));
        end
        @(posedge clk);
        #1 reset_n = 1'b0; we_i = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
